// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that drains a first-word-fall-through FIFO: start bit,
// DBIT data bits LSB-first, optional parity, then a stop period of SB_TICK ticks.
module uart_tx_fifo_reader #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_s_tick,
  input  logic            i_tx_en,
  input  logic            i_fifo_empty,
  input  logic [DBIT-1:0] i_fifo_data,
  output logic            o_fifo_rd,
  output logic            o_tx,
  output logic            o_busy,
  output logic            o_tx_done_tick
);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  localparam logic [4:0] BIT_LAST  = 5'd15;
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);

  state_t            r_state, w_state_next;
  logic [4:0]        r_s, w_s_next;
  logic [2:0]        r_n, w_n_next;
  logic [DBIT-1:0]   r_b, w_b_next;
  logic              r_par, w_par_next;
  logic              r_tx, w_tx_next;
  logic              w_fifo_rd, w_done;

  function automatic logic parity_bit(input logic [DBIT-1:0] d);
    if (PARITY == 2) begin
      return ~(^d);
    end else begin
      return ^d;
    end
  endfunction

  // State, counters, shift register and the registered serial line
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_s     <= 5'd0;
      r_n     <= 3'd0;
      r_b     <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_s     <= w_s_next;
      r_n     <= w_n_next;
      r_b     <= w_b_next;
      r_par   <= w_par_next;
      r_tx    <= w_tx_next;
    end
  end

  // Next-state logic; the pop is gated by reset so a held reset never drains the FIFO
  always_comb begin
    w_state_next = r_state;
    w_s_next     = r_s;
    w_n_next     = r_n;
    w_b_next     = r_b;
    w_par_next   = r_par;
    w_fifo_rd    = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_tx_en && !i_fifo_empty && !i_reset) begin
          w_b_next     = i_fifo_data;
          w_par_next   = parity_bit(i_fifo_data);
          w_s_next     = 5'd0;
          w_fifo_rd    = 1'b1;
          w_state_next = ST_START;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_START: begin
        if (i_s_tick && r_s == BIT_LAST) begin
          w_s_next     = 5'd0;
          w_n_next     = 3'd0;
          w_state_next = ST_DATA;
        end else if (i_s_tick) begin
          w_s_next = r_s + 5'd1;
        end else begin
          w_s_next = r_s;
        end
      end
      ST_DATA: begin
        if (i_s_tick && r_s == BIT_LAST) begin
          w_s_next = 5'd0;
          w_b_next = r_b >> 1;
          if (r_n == N_LAST) begin
            w_state_next = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            w_n_next = r_n + 3'd1;
          end
        end else if (i_s_tick) begin
          w_s_next = r_s + 5'd1;
        end else begin
          w_s_next = r_s;
        end
      end
      ST_PARITY: begin
        if (i_s_tick && r_s == BIT_LAST) begin
          w_s_next     = 5'd0;
          w_state_next = ST_STOP;
        end else if (i_s_tick) begin
          w_s_next = r_s + 5'd1;
        end else begin
          w_s_next = r_s;
        end
      end
      ST_STOP: begin
        if (i_s_tick && r_s == STOP_LAST) begin
          w_s_next     = 5'd0;
          w_done       = 1'b1;
          w_state_next = ST_IDLE;
        end else if (i_s_tick) begin
          w_s_next = r_s + 5'd1;
        end else begin
          w_s_next = r_s;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_s_next     = 5'd0;
      end
    endcase
  end

  // Line level follows the state being entered, so tx falls one clk after the pop
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      ST_START:  w_tx_next = 1'b0;
      ST_DATA:   w_tx_next = w_b_next[0];
      ST_PARITY: w_tx_next = w_par_next;
      default:   w_tx_next = 1'b1;
    endcase
  end

  assign o_tx           = r_tx;
  assign o_busy         = (r_state != ST_IDLE);
  assign o_fifo_rd      = w_fifo_rd;
  assign o_tx_done_tick = w_done;

endmodule
